// File: rtl/io_port_pkg.sv
// Shared sizing for the in/out port unit: default word width, FIFO depth
// and the occupancy-count width rule, kept here so top, FIFO and bench agree.
package io_port_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 4;

    // Counts must reach DEPTH itself, hence the +1.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/io_port_if.sv
// Port-unit bus bundle: CPU-side in/out strobes, device-side valid/ready links,
// flags and occupancy. slave = port unit view, master = control unit/device view.
interface io_port_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 3
);
    logic              OutputWrite;
    logic [DATA_W-1:0] OutData;
    logic              InRead;
    logic [DATA_W-1:0] InData;
    logic              InValid;
    logic              TxValid;
    logic [DATA_W-1:0] TxData;
    logic              TxReady;
    logic              RxValid;
    logic [DATA_W-1:0] RxData;
    logic              RxReady;
    logic              ClearFlags;
    logic              OutOverflow;
    logic              InUnderflow;
    logic [CNT_W-1:0]  TxCount;
    logic [CNT_W-1:0]  RxCount;

    modport slave (
        input  OutputWrite, OutData, InRead, TxReady, RxValid, RxData, ClearFlags,
        output InData, InValid, TxValid, TxData, RxReady,
               OutOverflow, InUnderflow, TxCount, RxCount
    );

    modport master (
        output OutputWrite, OutData, InRead, TxReady, RxValid, RxData, ClearFlags,
        input  InData, InValid, TxValid, TxData, RxReady,
               OutOverflow, InUnderflow, TxCount, RxCount
    );

endinterface

// File: rtl/io_port_fifo.sv
// Circular-buffer FIFO with zero-latency show-ahead head (rdata is 0 when empty).
// Push is ignored when full unless popping in the same cycle; pop ignored when empty.
module io_fifo
    import io_port_pkg::*;
#(
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int DEPTH  = DEPTH_DEF,
    localparam int CNT_W  = cnt_w(DEPTH),
    localparam int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)
                count <= count + CNT_W'(1);
            else if (!do_push && do_pop)
                count <= count - CNT_W'(1);
        end
    end

    // Storage needs no reset: the head is masked to 0 whenever count is 0.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/io_port_unit.sv
// Peripheral end of in/out: OutputWrite pushes TX FIFO (drained over TxValid/TxReady),
// RX FIFO fed by RxValid/RxReady is popped by InRead; head visible same cycle, pop at edge.
module io_port_unit
    import io_port_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = cnt_w(DEPTH)
) (
    input  logic       CLK,
    input  logic       Reset_n,
    io_port_if.slave   bus
);

    logic              tx_push;
    logic              tx_pop;
    logic              tx_full;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [CNT_W-1:0]  tx_count;

    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic [CNT_W-1:0]  rx_count;

    logic              out_overflow;
    logic              in_underflow;
    logic              overflow_evt;
    logic              underflow_evt;

    // A full TX FIFO still takes a write when the device drains the head this cycle.
    assign tx_pop   = ~tx_empty & bus.TxReady;
    assign tx_push  = bus.OutputWrite & (~tx_full | tx_pop);

    // RxReady is derived from occupancy only, so no drops and no comb path from RxValid.
    assign rx_push  = bus.RxValid & ~rx_full;
    assign rx_pop   = bus.InRead & ~rx_empty;

    assign overflow_evt  = bus.OutputWrite & tx_full & ~tx_pop;
    assign underflow_evt = bus.InRead & rx_empty;

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_tx_fifo (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .push    (tx_push),
        .pop     (tx_pop),
        .wdata   (bus.OutData),
        .rdata   (tx_head),
        .count   (tx_count),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    io_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_rx_fifo (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .push    (rx_push),
        .pop     (rx_pop),
        .wdata   (bus.RxData),
        .rdata   (rx_head),
        .count   (rx_count),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    // Set beats clear when both land in the same cycle.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            out_overflow <= 1'b0;
            in_underflow <= 1'b0;
        end else begin
            out_overflow <= overflow_evt  | (out_overflow & ~bus.ClearFlags);
            in_underflow <= underflow_evt | (in_underflow & ~bus.ClearFlags);
        end
    end

    assign bus.TxValid     = ~tx_empty;
    assign bus.TxData      = tx_head;
    assign bus.TxCount     = tx_count;
    assign bus.InValid     = ~rx_empty;
    assign bus.InData      = rx_head;
    assign bus.RxReady     = ~rx_full;
    assign bus.RxCount     = rx_count;
    assign bus.OutOverflow = out_overflow;
    assign bus.InUnderflow = in_underflow;

endmodule

// File: tb/tb_io_port_unit.sv
// Directed bench for io_port_unit: reset, TX overflow/drain order, full push+pop,
// RX back-pressure and wrap, RX push+pop, underflow and flag clear.
module tb_io_port_unit;
    import io_port_pkg::*;

    localparam int DW = 16;
    localparam int DP = 4;
    localparam int CW = cnt_w(DP);

    logic CLK;
    logic Reset_n;
    int   checks;
    int   errors;

    io_port_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    io_port_unit #(.DATA_W(DW), .DEPTH(DP), .CNT_W(CW)) dut (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle; all checks land 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    logic [DW-1:0] tx_words [5];
    logic [DW-1:0] tx_sim   [4];

    initial begin
        checks = 0;
        errors = 0;
        tx_words = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        tx_sim   = '{16'hB002, 16'hB003, 16'hB004, 16'hAAAA};

        Reset_n         = 1'b0;
        bus.OutputWrite = 1'b0;
        bus.OutData     = '0;
        bus.InRead      = 1'b0;
        bus.TxReady     = 1'b0;
        bus.RxValid     = 1'b0;
        bus.RxData      = '0;
        bus.ClearFlags  = 1'b0;
        step();
        step();

        chk("rst_txvalid", 32'(bus.TxValid), 0);
        chk("rst_invalid", 32'(bus.InValid), 0);
        chk("rst_rxready", 32'(bus.RxReady), 1);
        chk("rst_indata", 32'(bus.InData), 0);
        chk("rst_txdata", 32'(bus.TxData), 0);
        chk("rst_txcount", 32'(bus.TxCount), 0);
        chk("rst_rxcount", 32'(bus.RxCount), 0);
        chk("rst_ovf", 32'(bus.OutOverflow), 0);
        chk("rst_udf", 32'(bus.InUnderflow), 0);
        Reset_n = 1'b1;

        // Mid-cycle reset discards buffered TX words immediately.
        bus.OutputWrite = 1'b1;
        bus.OutData     = 16'h1234;
        step();
        bus.OutData     = 16'h5678;
        step();
        bus.OutputWrite = 1'b0;
        chk("pre_rst_txcount", 32'(bus.TxCount), 2);
        chk("pre_rst_txdata", 32'(bus.TxData), 32'h1234);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("async_rst_txvalid", 32'(bus.TxValid), 0);
        chk("async_rst_txcount", 32'(bus.TxCount), 0);
        #3;
        Reset_n = 1'b1;
        step();
        chk("post_rst_txcount", 32'(bus.TxCount), 0);
        chk("post_rst_txdata", 32'(bus.TxData), 0);
        chk("post_rst_txvalid", 32'(bus.TxValid), 0);

        // TX fill past capacity with the device stalled.
        bus.TxReady = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.OutputWrite = 1'b1;
            bus.OutData     = tx_words[i];
            step();
        end
        bus.OutputWrite = 1'b0;
        chk("tx_fill_count", 32'(bus.TxCount), 4);
        chk("tx_fill_ovf", 32'(bus.OutOverflow), 1);
        chk("tx_fill_valid", 32'(bus.TxValid), 1);
        step();
        chk("tx_stall_stable", 32'(bus.TxData), 32'h1111);
        bus.TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tx_drain_%0d", i), 32'(bus.TxData), 32'(tx_words[i]));
            step();
        end
        bus.TxReady = 1'b0;
        chk("tx_drain_valid", 32'(bus.TxValid), 0);
        chk("tx_drain_count", 32'(bus.TxCount), 0);
        bus.ClearFlags = 1'b1;
        step();
        bus.ClearFlags = 1'b0;
        chk("ovf_clear", 32'(bus.OutOverflow), 0);

        // Full TX FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) begin
            bus.OutputWrite = 1'b1;
            bus.OutData     = 16'hB001 + 16'(i);
            step();
        end
        chk("tx_full_count", 32'(bus.TxCount), 4);
        bus.OutData = 16'hAAAA;
        bus.TxReady = 1'b1;
        step();
        bus.OutputWrite = 1'b0;
        bus.TxReady     = 1'b0;
        chk("tx_sim_count", 32'(bus.TxCount), 4);
        chk("tx_sim_ovf", 32'(bus.OutOverflow), 0);
        bus.TxReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("tx_sim_drain_%0d", i), 32'(bus.TxData), 32'(tx_sim[i]));
            step();
        end
        bus.TxReady = 1'b0;
        chk("tx_sim_empty", 32'(bus.TxValid), 0);

        // RX stream 1..6: back-pressure after 4, then pops across pointer wrap.
        bus.RxValid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            bus.RxData = 16'(i);
            step();
        end
        bus.RxData = 16'd5;
        step();
        step();
        chk("rx_full_count", 32'(bus.RxCount), 4);
        chk("rx_full_ready", 32'(bus.RxReady), 0);
        chk("rx_full_head", 32'(bus.InData), 1);
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("rx_in_%0d", k), 32'(bus.InData), 32'(k));
            bus.InRead = 1'b1;
            step();
            bus.InRead = 1'b0;
            step();
            if (k == 1) bus.RxData = 16'd6;
            if (k == 2) begin
                bus.RxValid = 1'b0;
                chk("rx_refill_count", 32'(bus.RxCount), 4);
            end
        end
        chk("rx_drain_count", 32'(bus.RxCount), 0);
        chk("rx_drain_invalid", 32'(bus.InValid), 0);
        chk("rx_drain_ready", 32'(bus.RxReady), 1);

        // RX push and pop in the same cycle.
        bus.RxValid = 1'b1;
        bus.RxData  = 16'h000A;
        step();
        bus.RxData  = 16'h000B;
        step();
        chk("rx_sim_pre_count", 32'(bus.RxCount), 2);
        chk("rx_sim_pre_head", 32'(bus.InData), 32'h000A);
        bus.RxData = 16'h000C;
        bus.InRead = 1'b1;
        step();
        bus.RxValid = 1'b0;
        chk("rx_sim_count", 32'(bus.RxCount), 2);
        chk("rx_sim_head", 32'(bus.InData), 32'h000B);
        step();
        chk("rx_sim_head2", 32'(bus.InData), 32'h000C);
        step();
        bus.InRead = 1'b0;
        chk("rx_sim_empty", 32'(bus.RxCount), 0);
        chk("rx_sim_noudf", 32'(bus.InUnderflow), 0);

        // Underflow and flag clear priority.
        bus.InRead = 1'b1;
        #1;
        chk("udf_indata", 32'(bus.InData), 0);
        step();
        bus.InRead = 1'b0;
        chk("udf_set", 32'(bus.InUnderflow), 1);
        chk("udf_count", 32'(bus.RxCount), 0);
        bus.InRead     = 1'b1;
        bus.ClearFlags = 1'b1;
        step();
        bus.InRead = 1'b0;
        chk("udf_set_wins", 32'(bus.InUnderflow), 1);
        step();
        bus.ClearFlags = 1'b0;
        chk("udf_cleared", 32'(bus.InUnderflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Peripheral end of the processor's `in`/`out` instruction protocol.
- Sits between the multicycle control unit/datapath and an external device.
- Buffers words written by `out` (OutputWrite strobe) in a TX FIFO and drains them over a valid/ready link.
- Buffers words arriving from the device in an RX FIFO and presents the head word to the register write-back mux (MemtoReg = 2) for `in`.

Parameters:
- DATA_W, 16, word width (register width of the datapath).
- DEPTH, 4, entries per FIFO; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of occupancy counts.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- OutputWrite  in  1  one-cycle strobe from control unit `out` state; push OutData into TX FIFO.
- OutData  in  DATA_W  register-file read data for `out`.
- InRead  in  1  one-cycle strobe from control unit `in` state; pop RX FIFO head.
- InData  out  DATA_W  RX FIFO head (show-ahead); 0 when RX empty.
- InValid  out  1  RX FIFO non-empty.
- TxValid  out  1  TX FIFO non-empty.
- TxData  out  DATA_W  TX FIFO head.
- TxReady  in  1  device accepts TxData when TxValid & TxReady at rising edge.
- RxValid  in  1  device offers RxData.
- RxData  in  DATA_W  device word.
- RxReady  out  1  = RX FIFO not full; word taken when RxValid & RxReady at rising edge.
- ClearFlags  in  1  synchronous clear of sticky flags.
- OutOverflow  out  1  sticky: OutputWrite dropped because TX FIFO was full.
- InUnderflow  out  1  sticky: InRead while RX FIFO empty.
- TxCount  out  CNT_W  TX occupancy.
- RxCount  out  CNT_W  RX occupancy.

Behaviour:
- Reset (Reset_n low, asynchronous, immediate):
  - Pointers and counts = 0; sticky flags = 0.
  - TxValid = 0, InValid = 0, RxReady = 1, InData = 0, TxData = 0.
  - Buffered data is discarded. An in-flight handshake in the reset cycle is not completed.
  - Release is synchronous to CLK: first accept on the first rising edge after Reset_n goes high.
- Each FIFO is a circular buffer: read pointer, write pointer, count.
  - Pointers wrap from DEPTH-1 to 0.
  - Head output is combinational from the storage array (zero-latency show-ahead).
- TX side:
  - Push = OutputWrite & (not full | pop this cycle).
  - Pop = TxValid & TxReady.
  - Full with simultaneous push and pop: both happen, count stays DEPTH, no overflow.
  - Full with push but no pop: word dropped, count unchanged, OutOverflow set next edge.
  - TxData stays stable while TxValid & !TxReady.
- RX side:
  - Push = RxValid & RxReady.
  - Pop = InRead & InValid.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - RxReady depends only on count (no combinational path from RxValid or InRead).
  - Full: RxReady = 0, so no drops on RX.
- `in` timing:
  - The control unit writes back InData combinationally during the same cycle InRead is high.
  - The pop takes effect at that cycle's closing edge, so latency from strobe to new head is 1 cycle.
  - InRead with RX empty: InData = 0 is written, no pointer change, InUnderflow set.
- `out` timing: OutData is sampled on the edge ending the OutputWrite cycle. TxValid rises no earlier than the next cycle.
- Sticky flags:
  - Set by their event; cleared by ClearFlags.
  - ClearFlags and a set event in the same cycle: set wins.
- Counts always in 0..DEPTH. The count width rule stays valid for any power-of-two DEPTH.
- TX and RX are fully independent; all four push/pop events may coincide in one cycle.

Decomposition:
- Shared package io_port_pkg: DATA_W default, DEPTH default, CNT_W function.
- Sub-module io_fifo:
  - Parameters DATA_W, DEPTH.
  - Ports: CLK, Reset_n, push, pop, wdata, rdata, count, full, empty.
- io_port_unit instantiates io_fifo twice, plus the drop/underflow gating and flag registers.

Test Plan:
- Reset: write 2 words, assert Reset_n=0 mid-cycle -> TxValid=0, TxCount=0 immediately; after release, TxCount=0 and no stale word on TxData.
- TX fill and overflow: TxReady=0, OutputWrite with 0x1111, 0x2222, 0x3333, 0x4444, 0x5555 -> TxCount=4, OutOverflow=1. With TxReady=1 the drain order is 1111, 2222, 3333, 4444; 0x5555 never appears.
- TX full simultaneous: TX full, TxReady=1 and OutputWrite 0xAAAA in the same cycle -> TxCount stays 4, OutOverflow stays 0, 0xAAAA drains last.
- RX back-pressure and wrap: device streams 0x0001..0x0006 with RxValid=1, no InRead -> RxReady=0 after 4 words. Then pulse InRead 6 times, one per 2 cycles -> InData sequence 1..6 across pointer wrap, RxCount returns to 0.
- RX simultaneous push/pop: RxCount=2, RxValid & InRead in the same cycle -> RxCount stays 2, head advances to the next word.
- Underflow and flag clear: InRead with RX empty -> InData=0, InUnderflow=1. ClearFlags=1 while another empty InRead occurs -> flag stays 1; ClearFlags alone -> flag 0.
